// File: rtl/cpu_fetch_pkg.sv
// Shared types and word constants for the instruction fetch unit.
// Types and constants only: no logic, so there is no latency or backpressure.
// Imported by both the top level and the program store.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [19:0] FETCH_NOP_WORD  = 20'h00000;
    localparam logic [19:0] FETCH_HALT_WORD = 20'hFFFFF;

endpackage

// File: rtl/fetch_prog_mem.sv
// Program store: one write port and one synchronous read port, write-first on address match.
// Latency: read data appears one clock after the read address is presented.
// No backpressure: a write or read is accepted on every edge.
module fetch_prog_mem
    import cpu_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_BITS-1:0]   waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]   raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [INSTR_WIDTH-1:0] mem [0:DEPTH-1];

    // Contents deliberately have no reset; a program survives rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequencer issuing program-store words to simple_cpu, one per clock from address 0 (FETCH_STEP_EN: step-gated).
// Latency: first word one clock after start; HALT word shown one cycle, then DONE.
// No backpressure; the optional step input paces issue.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     ADDR_BITS   = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(FETCH_NOP_WORD),
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = INSTR_WIDTH'(FETCH_HALT_WORD)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [ADDR_BITS-1:0]   load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic                   stop,
`ifdef FETCH_STEP_EN
    input  logic                   step,
`endif
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   done
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d, rd_addr;
    logic                   vld_q, vld_d;
    logic                   done_q, done_d;
    logic                   mem_we, advance, halt_seen;
    logic [INSTR_WIDTH-1:0] rd_data;

`ifdef FETCH_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign mem_we    = load_en && (state_q != RUN);
    // The memory output is the issued word whenever vld_q is set.
    assign halt_seen = vld_q && (rd_data == HALT_WORD);

    fetch_prog_mem #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_BITS   (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = 1'b0;
        done_d  = done_q;
        rd_addr = pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (!stop && start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    rd_addr = '0;
                    vld_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (halt_seen) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (advance) begin
                    pc_d    = pc_q + ADDR_BITS'(1);
                    rd_addr = pc_q + ADDR_BITS'(1);
                    vld_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign instruction = vld_q ? rd_data : NOP_WORD;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;

endmodule
